// File: rtl/uart_pkg.sv
// Shared UART constants: fractional bit timing, frame slot indices, FSM states.
package uart_pkg;

    // Bit timing defaults, identical on transmit and receive sides
    localparam int unsigned BIT_BASE_DEF = 168;
    localparam logic [9:0]  BIT_MASK_DEF = 10'h3DF;

    // Frame layout: start, 8 data bits LSB first, stop
    localparam int unsigned FRAME_SLOTS = 10;
    localparam int unsigned SLOT_W      = 4;
    localparam logic [SLOT_W-1:0] START = 4'd0;
    localparam logic [SLOT_W-1:0] STOP  = 4'd9;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } uart_state_e;

    // Clocks in a given slot: base period plus the slot's mask bit
    function automatic int unsigned slot_period(input int unsigned       base,
                                                input logic [9:0]        mask,
                                                input logic [SLOT_W-1:0] slot);
        if (slot < SLOT_W'(FRAME_SLOTS)) begin
            return base + 32'(mask[slot]);
        end
        return base;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-slot bit-period counter with mid-bit and end-of-bit strobes.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned BIT_BASE  = BIT_BASE_DEF,
    parameter logic [9:0]  BIT_MASK  = BIT_MASK_DEF
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic [SLOT_W-1:0]    slot_i,
    input  logic                 run_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 mid_o_c,
    output logic                 end_o_c
);

    // One extra bit so BIT_BASE+1 never wraps in the comparisons
    localparam int unsigned PW = CNT_WIDTH + 1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [PW-1:0]        period_c;
    logic [PW-1:0]        cnt_ext_c;

    // Period of the current slot and the two strobe decodes
    always_comb begin
        period_c  = PW'(slot_period(BIT_BASE, BIT_MASK, slot_i));
        cnt_ext_c = {1'b0, cnt_q};
        mid_o_c   = (cnt_ext_c == (period_c >> 1));
        end_o_c   = (cnt_ext_c == (period_c - PW'(1)));
    end

    // Counter: cleared on request, otherwise counts and wraps at end of slot
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= end_o_c ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx_frac.sv
// 8N1 UART receiver with fractional bit timing and a one-entry valid/ready output.
module uart_rx_frac
    import uart_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned BIT_BASE  = BIT_BASE_DEF,
    parameter logic [9:0]  BIT_MASK  = BIT_MASK_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    logic                 sync1_q;
    logic                 rx_s_q;
    logic                 rx_d_q;
    uart_state_e          state_q;
    logic [SLOT_W-1:0]    slot_q;
    logic [7:0]           shift_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;

    logic [CNT_WIDTH-1:0] cnt_c;
    logic                 mid_c;
    logic                 end_c;
    logic                 start_c;
    logic                 consume_c;
    logic                 leave_c;
    logic                 timer_run_c;
    logic                 timer_clr_c;

    uart_bit_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .BIT_BASE  (BIT_BASE),
        .BIT_MASK  (BIT_MASK)
    ) u_timer (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .slot_i  (slot_q),
        .run_i   (timer_run_c),
        .clr_i   (timer_clr_c),
        .cnt_o   (cnt_c),
        .mid_o_c (mid_c),
        .end_o_c (end_c)
    );

    // Two-stage synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // Start edge (only with the timer parked), consume handshake, early exits
    always_comb begin
        start_c     = rx_d_q & ~rx_s_q & (cnt_c == '0);
        consume_c   = rx_valid_q & rx_ready;
        leave_c     = (state_q == FRAME) & mid_c &
                      (((slot_q == START) & rx_s_q) | (slot_q == STOP));
        timer_run_c = (state_q == FRAME);
        timer_clr_c = (state_q == IDLE) | leave_c;
    end

    // Frame FSM, shift register and holding register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            slot_q      <= START;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (consume_c) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q <= FRAME;
                        slot_q  <= START;
                        busy_q  <= 1'b1;
                    end
                end
                FRAME: begin
                    if (mid_c) begin
                        if (slot_q == START) begin
                            // Line back high at mid-start: treat as a glitch
                            if (rx_s_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else if (slot_q == STOP) begin
                            // Finish at the stop sample so a following start is not missed
                            state_q <= IDLE;
                            slot_q  <= START;
                            busy_q  <= 1'b0;
                            if (rx_s_q) begin
                                if (!rx_valid_q || consume_c) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            shift_q[3'(slot_q - SLOT_W'(1))] <= rx_s_q;
                        end
                    end else if (end_c) begin
                        slot_q <= slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frac.sv
// Testbench for uart_rx_frac: directed frame table, corner sequences, random traffic.
module tb_uart_rx_frac;

    localparam int unsigned CNT_WIDTH = 8;
    localparam int unsigned BIT_BASE  = 168;
    localparam logic [9:0]  BIT_MASK  = 10'h3DF;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_frac #(
        .CNT_WIDTH (CNT_WIDTH),
        .BIT_BASE  (BIT_BASE),
        .BIT_MASK  (BIT_MASK)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct { int done; logic ok; logic [7:0] data; } comp_t;
    typedef struct { int lo; int hi; } span_t;
    typedef struct { int when; int idx; } chk_t;
    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         stop_len;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    comp_t comp_q[$];
    span_t span_q[$];
    chk_t  chk_q[$];
    vec_t  vecs[7];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_off;
    int   busy_cnt = 0;
    int   act_cnt = 0;
    logic rand_ready = 1'b0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       prev_ready = 1'b0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(posedge CLOCK) begin
        #1;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end

    function automatic int period(input int i);
        logic [9:0] m;
        m = BIT_MASK;
        return int'(BIT_BASE) + (m[4'(i)] ? 1 : 0);
    endfunction

    function automatic int slots_before(input int s);
        int t = 0;
        for (int j = 0; j < s; j++) t += period(j);
        return t;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // Reference: holding register driven by predicted completion times, busy by frame spans
    always @(negedge CLOCK) begin
        logic exp_busy;
        int   k;
        if (!RESET_N) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            comp_q.delete();
            span_q.delete();
            exp_busy = 1'b0;
        end else begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            if (m_valid && prev_ready) m_valid = 1'b0;
            while (comp_q.size() > 0 && comp_q[0].done < cyc) void'(comp_q.pop_front());
            if (comp_q.size() > 0 && comp_q[0].done == cyc) begin
                if (comp_q[0].ok) begin
                    if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = comp_q[0].data;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
                void'(comp_q.pop_front());
            end
            while (span_q.size() > 0 && span_q[0].hi < cyc) void'(span_q.pop_front());
            exp_busy = (span_q.size() > 0) && (span_q[0].lo <= cyc);
        end
        prev_ready = rx_ready;
        if (busy === 1'b1) busy_cnt++;
        if (rx_valid === 1'b1 || frame_err === 1'b1) act_cnt++;

        total++;
        if ({busy, rx_valid, frame_err, overrun, rx_data} !==
            {exp_busy, m_valid, m_ferr, m_ovr, m_data}) begin
            bad++;
            $display("FAIL cycle_model cyc=%0d got busy=%b valid=%b ferr=%b ovr=%b data=%h want busy=%b valid=%b ferr=%b ovr=%b data=%h",
                     cyc, busy, rx_valid, frame_err, overrun, rx_data,
                     exp_busy, m_valid, m_ferr, m_ovr, m_data);
        end

        if (chk_q.size() > 0 && chk_q[0].when == cyc) begin
            k = chk_q[0].idx;
            void'(chk_q.pop_front());
            total++;
            if (rx_valid !== vecs[k].exp_valid || rx_data !== vecs[k].exp_data ||
                frame_err !== vecs[k].exp_ferr || overrun !== vecs[k].exp_ovr) begin
                bad++;
                $display("FAIL vec%0d cyc=%0d got valid=%b data=%h ferr=%b ovr=%b want valid=%b data=%h ferr=%b ovr=%b",
                         k, cyc, rx_valid, rx_data, frame_err, overrun,
                         vecs[k].exp_valid, vecs[k].exp_data, vecs[k].exp_ferr, vecs[k].exp_ovr);
            end
        end
    end

    // Drive one frame on the pin; caller is 1 time unit after a rising edge
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        int c0;
        c0 = cyc;
        comp_q.push_back('{done: c0 + done_off, ok: stop, data: d});
        span_q.push_back('{lo: c0 + 3, hi: c0 + done_off - 1});
        rx = 1'b0;
        wait_cycles(period(0));
        for (int i = 1; i <= 8; i++) begin
            rx = d[3'(i - 1)];
            wait_cycles(period(i));
        end
        rx = stop;
        wait_cycles(stop_len);
        rx = 1'b1;
    endtask

    // Short low pulse rejected at the mid-start sample; returns once receiver is idle
    task automatic send_glitch(input int len);
        int c0;
        c0 = cyc;
        span_q.push_back('{lo: c0 + 3, hi: c0 + 3 + period(0) / 2});
        rx = 1'b0;
        wait_cycles(len);
        rx = 1'b1;
        wait_cycles(period(0) / 2 + 2 - len);
    endtask

    task automatic apply_vec(input int k);
        rx_ready = vecs[k].ready;
        chk_q.push_back('{when: cyc + done_off, idx: k});
        send_frame(vecs[k].data, vecs[k].stop, vecs[k].stop_len);
    endtask

    initial begin
        RESET_N  = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        done_off = 4 + slots_before(9) + period(9) / 2;

        vecs[0] = '{8'hA5, 1'b1, 169, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 169, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 169, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 169, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1,  86, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 169, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 169, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

        #2 RESET_N = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        total++;
        if ({busy, rx_valid, frame_err, overrun, rx_data} !== 12'h000) begin
            bad++;
            $display("FAIL reset_state got %b want 000000000000",
                     {busy, rx_valid, frame_err, overrun, rx_data});
        end
        RESET_N = 1'b1;
        wait_cycles(5);

        apply_vec(0);
        wait_cycles(3);

        busy_cnt = 0;
        act_cnt  = 0;
        send_glitch(40);
        wait_cycles(20);
        total++;
        if (busy_cnt != 85 || act_cnt != 0) begin
            bad++;
            $display("FAIL glitch got busy_cycles=%0d activity=%0d want 85 0", busy_cnt, act_cnt);
        end

        apply_vec(1);
        wait_cycles(5);
        apply_vec(2);
        apply_vec(3);
        wait_cycles(2);
        apply_vec(4);
        apply_vec(5);
        wait_cycles(5);

        // Reset in the middle of slot 4 of a frame
        begin
            logic [7:0] d;
            int         c0;
            d  = 8'h99;
            c0 = cyc;
            span_q.push_back('{lo: c0 + 3, hi: c0 + 100000});
            rx = 1'b0;
            wait_cycles(period(0));
            for (int i = 1; i <= 3; i++) begin
                rx = d[3'(i - 1)];
                wait_cycles(period(i));
            end
            rx = d[3];
            wait_cycles(50);
            RESET_N = 1'b0;
            #1;
            total++;
            if ({busy, rx_valid, frame_err, overrun, rx_data} !== 12'h000) begin
                bad++;
                $display("FAIL midframe_reset got %b want 000000000000",
                         {busy, rx_valid, frame_err, overrun, rx_data});
            end
            rx = 1'b1;
            wait_cycles(3);
            RESET_N = 1'b1;
            wait_cycles(5);
        end
        apply_vec(6);
        wait_cycles(5);

        // Random traffic with random consumer back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            int kind;
            kind = int'($urandom_range(0, 7));
            if (kind == 0) begin
                send_glitch(int'($urandom_range(1, 80)));
                wait_cycles(int'($urandom_range(1, 10)));
            end else begin
                logic stop;
                stop = (kind == 1) ? 1'b0 : 1'b1;
                send_frame(8'($urandom), stop, int'($urandom_range(86, 169)));
                if (!stop) wait_cycles(int'($urandom_range(1, 10)));
                else       wait_cycles(int'($urandom_range(0, 10)));
            end
        end
        rand_ready = 1'b0;
        wait_cycles(1);
        rx_ready = 1'b1;
        wait_cycles(1800);

        total++;
        if (comp_q.size() != 0 || chk_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d checks=%0d want 0 0", comp_q.size(), chk_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
